// File: rtl/nibble_serial_sub_pkg.sv
// Shared definitions for the nibble-serial subtractor controller.
//   NIBBLE_W   : width of the shared subtractor slice (4 bits)
//   state_t    : controller states IDLE / CALC / DONE
//   cnt_width  : nibble-counter width, clog2(nibbles) but never below 1
package nibble_serial_sub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int nibbles);
        int w;
        w = $clog2(nibbles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/nibble_sub_slice.sv
// Combinational 4-bit borrow-chained subtractor slice: {bout, diff} = a - b - bin.
// Ports:
//   a, b  : 4-bit minuend / subtrahend nibbles
//   bin   : borrow in
//   diff  : 4-bit difference
//   bout  : borrow out (1 when a < b + bin)
module nibble_sub_slice
    import nibble_serial_sub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                bin,
    output logic [NIBBLE_W-1:0] diff,
    output logic                bout
);

    logic [NIBBLE_W:0] full;

    // One extra bit catches the borrow as the sign of the widened result.
    assign full = {1'b0, a} - {1'b0, b} - {{NIBBLE_W{1'b0}}, bin};
    assign diff = full[NIBBLE_W-1:0];
    assign bout = full[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_sub_ctrl.sv
// Multi-cycle WIDTH-bit subtractor: diff = a - b - bin, one nibble per clock,
// LSB first, through a single shared nibble_sub_slice.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : request, accepted only in IDLE or DONE
//   a, b, bin   : operands, captured on an accepted start
//   busy        : high in CALC
//   done        : one-cycle pulse when diff/barrow are updated
//   diff        : registered result, held until the next completion
//   barrow      : registered borrow out of the MSB nibble
//   zero        : (NIBBLE_SERIAL_SUB_ZERO_FLAG_EN only) completed diff == 0
//   state_dbg   : current controller state
// Optional feature macro: NIBBLE_SERIAL_SUB_ZERO_FLAG_EN
// Handshake: start is a level request sampled on the rising edge while the
// controller is IDLE or DONE; done pulses for exactly one cycle per accepted
// start, NIBBLES+1 edges after acceptance. There is no backpressure.
module nibble_serial_sub_ctrl
    import nibble_serial_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             barrow,
`ifdef NIBBLE_SERIAL_SUB_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic [1:0]       state_dbg
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = cnt_width(NIBBLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
        $fatal(1, "nibble_serial_sub_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t                             state_q, state_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic                               brw_q, brw_d;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   a_q, a_d;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   b_q, b_d;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   shadow_q, shadow_d;
    logic [WIDTH-1:0]                   diff_q, diff_d;
    logic                               barrow_q, barrow_d;
`ifdef NIBBLE_SERIAL_SUB_ZERO_FLAG_EN
    logic                               nz_q, nz_d;
    logic                               zero_q, zero_d;
`endif

    logic [NIBBLE_W-1:0] sl_a, sl_b, sl_diff;
    logic                sl_bout;

    assign sl_a = a_q[cnt_q];
    assign sl_b = b_q[cnt_q];

    nibble_sub_slice u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .bin  (brw_q),
        .diff (sl_diff),
        .bout (sl_bout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        brw_d    = brw_q;
        a_d      = a_q;
        b_d      = b_q;
        shadow_d = shadow_q;
        diff_d   = diff_q;
        barrow_d = barrow_q;
`ifdef NIBBLE_SERIAL_SUB_ZERO_FLAG_EN
        nz_d     = nz_q;
        zero_d   = zero_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    cnt_d   = '0;
`ifdef NIBBLE_SERIAL_SUB_ZERO_FLAG_EN
                    nz_d    = 1'b0;
`endif
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                shadow_d[cnt_q] = sl_diff;
                brw_d           = sl_bout;
                cnt_d           = cnt_q + CNT_W'(1);
`ifdef NIBBLE_SERIAL_SUB_ZERO_FLAG_EN
                // Any non-zero nibble makes the whole result non-zero.
                nz_d            = nz_q | (|sl_diff);
`endif
                if (cnt_q == LAST) begin
                    // shadow_d already holds the final nibble here.
                    diff_d   = shadow_d;
                    barrow_d = sl_bout;
`ifdef NIBBLE_SERIAL_SUB_ZERO_FLAG_EN
                    zero_d   = ~nz_d;
`endif
                    cnt_d    = '0;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            brw_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            diff_q   <= '0;
            barrow_q <= 1'b0;
`ifdef NIBBLE_SERIAL_SUB_ZERO_FLAG_EN
            nz_q     <= 1'b0;
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            brw_q    <= brw_d;
            a_q      <= a_d;
            b_q      <= b_d;
            shadow_q <= shadow_d;
            diff_q   <= diff_d;
            barrow_q <= barrow_d;
`ifdef NIBBLE_SERIAL_SUB_ZERO_FLAG_EN
            nz_q     <= nz_d;
            zero_q   <= zero_d;
`endif
        end
    end

    assign busy      = (state_q == CALC);
    assign done      = (state_q == DONE);
    assign diff      = diff_q;
    assign barrow    = barrow_q;
    assign state_dbg = state_q;
`ifdef NIBBLE_SERIAL_SUB_ZERO_FLAG_EN
    assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_nibble_serial_sub_ctrl.sv
// Self-checking bench for nibble_serial_sub_ctrl (WIDTH=16 main instance,
// WIDTH=4 second instance). Optional macro: NIBBLE_SERIAL_SUB_ZERO_FLAG_EN.
module tb_nibble_serial_sub_ctrl;
    import nibble_serial_sub_pkg::*;

    localparam int W = 16;
    localparam int N = W / 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   a, b;
    logic           bin;
    logic           busy, done, barrow;
    logic [W-1:0]   diff;
    logic [1:0]     state_dbg;

    logic           start4;
    logic [3:0]     a4, b4;
    logic           bin4;
    logic           busy4, done4, barrow4;
    logic [3:0]     diff4;
    logic [1:0]     state_dbg4;
`ifdef NIBBLE_SERIAL_SUB_ZERO_FLAG_EN
    logic           zero, zero4;
`endif

    nibble_serial_sub_ctrl #(.WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .barrow(barrow),
`ifdef NIBBLE_SERIAL_SUB_ZERO_FLAG_EN
        .zero(zero),
`endif
        .state_dbg(state_dbg)
    );

    nibble_serial_sub_ctrl #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .barrow(barrow4),
`ifdef NIBBLE_SERIAL_SUB_ZERO_FLAG_EN
        .zero(zero4),
`endif
        .state_dbg(state_dbg4)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // scoreboard
    int           n_tests = 0;
    int           n_fail  = 0;
    int           accepted = 0;
    int           done_cnt = 0;
    logic [W:0]   exp_q[$];
    logic [W:0]   last_res;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // Reference: (W+1)-bit two's-complement a - b - bin.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic binv);
        logic [W:0] bx;
        bx = '0;
        bx[0] = binv;
        return {1'b0, av} - {1'b0, bv} - bx;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            default: return W'($urandom);
        endcase
    endfunction

    // driver: call at a negedge where the DUT is IDLE or DONE
    task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv,
                      input bit hold);
        logic [W:0] e;
        a = av; b = bv; bin = binv; start = 1'b1;
        exp_q.push_back(ref_sub(av, bv, binv));
        accepted++;
        for (int i = 1; i <= N; i++) begin
            @(negedge clk);
            check("busy", {31'd0, busy}, 32'd1);
            check("done_early", {31'd0, done}, 32'd0);
            check("diff_held", {15'd0, barrow, diff}, {15'd0, last_res});
            start = (hold && i < N);
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        end
        @(negedge clk);
        check("done", {31'd0, done}, 32'd1);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        e = exp_q.pop_front();
        check("result", {15'd0, barrow, diff}, {15'd0, e});
`ifdef NIBBLE_SERIAL_SUB_ZERO_FLAG_EN
        check("zero", {31'd0, zero}, {31'd0, (e[W-1:0] == '0)});
`endif
        last_res = e;
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        last_res = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {15'd0, barrow, diff}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, {30'd0, IDLE});
`ifdef NIBBLE_SERIAL_SUB_ZERO_FLAG_EN
        check("rst_zero", {31'd0, zero}, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // directed cases
        op(16'h1234, 16'h0235, 1'b0, 1'b0);
        check("dir_1234", {15'd0, barrow, diff}, 32'h0_0FFF);
        @(negedge clk);
        op(16'h0000, 16'h0001, 1'b0, 1'b1);
        check("dir_0_1", {15'd0, barrow, diff}, 32'h1_FFFF);
        // back-to-back: second op launched in the DONE cycle
        op(16'h8000, 16'h7FFF, 1'b1, 1'b0);
        check("dir_8000", {15'd0, barrow, diff}, 32'h0_0000);
        op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        op(16'h0000, 16'h0000, 1'b1, 1'b0);
        check("dir_0_0_1", {15'd0, barrow, diff}, 32'h1_FFFF);
        @(negedge clk);
        check("idle_after", {30'd0, busy, done}, 32'd0);

        // reset and start together: reset wins
        rst = 1'b1; start = 1'b1; a = 16'h5555; b = 16'h1111;
        @(negedge clk);
        check("rst_vs_start", {31'd0, busy}, 32'd0);
        rst = 1'b0; start = 1'b0;
        last_res = '0;
        @(negedge clk);

        // reset in the 2nd CALC cycle aborts the operation
        a = 16'hABCD; b = 16'h1234; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_diff", {15'd0, barrow, diff}, 32'd0);
        check("abort_state", {30'd0, state_dbg}, {30'd0, IDLE});
        rst = 1'b0;
        d0 = done_cnt;
        repeat (10) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 32'd0);

        // WIDTH=4 instance: one compute cycle
        a4 = 4'h3; b4 = 4'h5; bin4 = 1'b1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("w4_busy", {31'd0, busy4}, 32'd1);
        @(negedge clk);
        check("w4_done", {31'd0, done4}, 32'd1);
        check("w4_result", {27'd0, barrow4, diff4}, 32'h1D);
        @(negedge clk);

        // random sweep
        for (int i = 0; i < 1000; i++) begin
            op(pick(), pick(), 1'($urandom), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("done_count", done_cnt, accepted);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
